// File: rtl/mux_select_sequencer_pkg.sv
// rtl/mux_select_sequencer_pkg.sv - shared state encodings, address limits and settle range check for the mux sequencer
// Optional feature macro used by this slice: MUX_SELFCHECK_EN

`ifndef MUX_SEQ_DEFS_DONE
`define MUX_SEQ_DEFS_DONE
// True when a settle count is inside the supported 1..15 window
`define MUX_SEQ_SETTLE_RANGE_OK(s) (((s) >= mux_select_sequencer_pkg::SETTLE_MIN) && ((s) <= mux_select_sequencer_pkg::SETTLE_MAX))
`endif

package mux_select_sequencer_pkg;

   // Mux select address, address1 in the MSB
   typedef logic [1:0] addr_t;

   // Sequencer state encodings
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;

   // Final mux leg of a word
   localparam addr_t ADDR_LAST = 2'b11;

   // Supported settle window
   localparam int SETTLE_MIN = 1;
   localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/mux_select_sequencer_settle_counter.sv
// rtl/mux_select_sequencer_settle_counter.sv - settle counter with clear, enable and terminal count

module settle_counter #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic done
);

   logic [CNT_W-1:0] cnt;

   // Counter must be able to represent the terminal value
   generate
      if ((SETTLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_width_check
         $error("settle_counter: CNT_W too narrow for SETTLE_CYCLES-1");
      end
   endgenerate

   // Clear wins over enable so a new address always starts from zero
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Terminal count marks the last settle cycle of the current address
   assign done = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - serializes a 4-bit word through an external 4:1 mux (optional MUX_SELFCHECK_EN)

module mux_select_sequencer
   import mux_select_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [3:0] load_data,
   output logic       address0,
   output logic       address1,
   output logic       in0,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   input  logic       mux_out,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       bit_last,
`ifdef MUX_SELFCHECK_EN
   output logic       mismatch,
`endif
   output logic       busy
);

   logic [1:0] state;
   addr_t      addr;
   logic [3:0] in_q;
   logic       cnt_clear;
   logic       cnt_enable;
   logic       cnt_done;

   // Reject settle counts outside the supported window at elaboration
   generate
      if (!`MUX_SEQ_SETTLE_RANGE_OK(SETTLE_CYCLES)) begin : g_settle_check
         $error("mux_select_sequencer: SETTLE_CYCLES must be in 1..15");
      end
   endgenerate

   // Counter restarts on every accept and every sample; it only runs while settling
   assign cnt_clear  = (state != ST_SETTLE);
   assign cnt_enable = (state == ST_SETTLE) && !cnt_done;

   settle_counter #(
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .CNT_W        (CNT_W)
   ) u_settle_counter (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .enable(cnt_enable),
      .done  (cnt_done)
   );

   // State sequencing: accept, settle each address, sample, repeat for four legs
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_valid) begin
                  state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_done) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (addr == ADDR_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  state <= ST_SETTLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Held data lines and select address; address moves only on accept and sample edges
   always_ff @(posedge clk) begin
      if (reset) begin
         in_q <= 4'b0000;
         addr <= 2'b00;
      end else if ((state == ST_IDLE) && load_valid) begin
         in_q <= load_data;
         addr <= 2'b00;
      end else if ((state == ST_SAMPLE) && (addr != ADDR_LAST)) begin
         addr <= addr + 2'd1;
      end
   end

   // Sampled bit and its one-cycle qualifiers; mux_out is captured as-is, X/Z included
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         bit_last  <= 1'b0;
      end else if (state == ST_SAMPLE) begin
         bit_out   <= mux_out;
         bit_valid <= 1'b1;
         bit_last  <= (addr == ADDR_LAST);
      end else begin
         bit_valid <= 1'b0;
         bit_last  <= 1'b0;
      end
   end

`ifdef MUX_SELFCHECK_EN
   // Sticky flag when the returned mux value differs from the selected held line
   always_ff @(posedge clk) begin
      if (reset) begin
         mismatch <= 1'b0;
      end else if ((state == ST_SAMPLE) && (mux_out !== in_q[addr])) begin
         mismatch <= 1'b1;
      end
   end
`endif

   assign load_ready = (state == ST_IDLE);
   assign busy       = (state == ST_SETTLE) || (state == ST_SAMPLE);

   assign address0 = addr[0];
   assign address1 = addr[1];
   assign in0      = in_q[0];
   assign in1      = in_q[1];
   assign in2      = in_q[2];
   assign in3      = in_q[3];

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - directed bench for mux_select_sequencer with gate-delay mux models (optional MUX_SELFCHECK_EN)

module tb_mux_select_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   passes = 0;

   always #50 clk = ~clk;

   // DUT A: SETTLE_CYCLES=2
   logic       lv_a = 1'b0;
   logic [3:0] ld_a = 4'b0000;
   logic       force_a = 1'b0;
   logic       rdy_a, a0_a, a1_a, i0_a, i1_a, i2_a, i3_a, bo_a, bv_a, bl_a, busy_a;
   wire        mo_a;
   wire        na0_a, na1_a, s0_a, s1_a, s2_a, s3_a, mux_a;
`ifdef MUX_SELFCHECK_EN
   logic       mm_a;
`endif

   // DUT B: SETTLE_CYCLES=1
   logic       lv_b = 1'b0;
   logic [3:0] ld_b = 4'b0000;
   logic       rdy_b, a0_b, a1_b, i0_b, i1_b, i2_b, i3_b, bo_b, bv_b, bl_b, busy_b;
   wire        mo_b;
   wire        na0_b, na1_b, s0_b, s1_b, s2_b, s3_b, mux_b;
`ifdef MUX_SELFCHECK_EN
   logic       mm_b;
`endif

   // Structural 4:1 mux, three 50-unit stages (inverter, and, output driver)
   assign #50 na0_a = ~a0_a;
   assign #50 na1_a = ~a1_a;
   assign #50 s0_a  = na1_a & na0_a & i0_a;
   assign #50 s1_a  = na1_a & a0_a  & i1_a;
   assign #50 s2_a  = a1_a  & na0_a & i2_a;
   assign #50 s3_a  = a1_a  & a0_a  & i3_a;
   assign #50 mux_a = s0_a | s1_a | s2_a | s3_a;
   assign mo_a = force_a ? 1'b0 : mux_a;

   assign #50 na0_b = ~a0_b;
   assign #50 na1_b = ~a1_b;
   assign #50 s0_b  = na1_b & na0_b & i0_b;
   assign #50 s1_b  = na1_b & a0_b  & i1_b;
   assign #50 s2_b  = a1_b  & na0_b & i2_b;
   assign #50 s3_b  = a1_b  & a0_b  & i3_b;
   assign #50 mux_b = s0_b | s1_b | s2_b | s3_b;
   assign mo_b = mux_b;

   mux_select_sequencer #(.SETTLE_CYCLES(2), .CNT_W(4)) dut_a (
      .clk(clk), .reset(reset), .load_valid(lv_a), .load_ready(rdy_a), .load_data(ld_a),
      .address0(a0_a), .address1(a1_a), .in0(i0_a), .in1(i1_a), .in2(i2_a), .in3(i3_a),
      .mux_out(mo_a), .bit_out(bo_a), .bit_valid(bv_a), .bit_last(bl_a),
`ifdef MUX_SELFCHECK_EN
      .mismatch(mm_a),
`endif
      .busy(busy_a)
   );

   mux_select_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .load_valid(lv_b), .load_ready(rdy_b), .load_data(ld_b),
      .address0(a0_b), .address1(a1_b), .in0(i0_b), .in1(i1_b), .in2(i2_b), .in3(i3_b),
      .mux_out(mo_b), .bit_out(bo_b), .bit_valid(bv_b), .bit_last(bl_b),
`ifdef MUX_SELFCHECK_EN
      .mismatch(mm_b),
`endif
      .busy(busy_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         passes++;
      end
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, " ready"}, {31'd0, rdy_a}, 32'd1);
      check({tag, " busy"}, {31'd0, busy_a}, 32'd0);
      check({tag, " addr"}, {30'd0, a1_a, a0_a}, 32'd0);
      check({tag, " in"}, {28'd0, i3_a, i2_a, i1_a, i0_a}, 32'd0);
      check({tag, " bit_out"}, {31'd0, bo_a}, 32'd0);
      check({tag, " bit_valid"}, {31'd0, bv_a}, 32'd0);
      check({tag, " bit_last"}, {31'd0, bl_a}, 32'd0);
`ifdef MUX_SELFCHECK_EN
      check({tag, " mismatch"}, {31'd0, mm_a}, 32'd0);
`endif
   endtask

   // One word on DUT A; optionally keep load_valid high with next_data for a back-to-back word
   task automatic word_a(input string tag, input logic [3:0] data, input bit hold, input logic [3:0] next_data);
      int a;
      @(negedge clk);
      lv_a = 1'b1;
      ld_a = data;
      @(posedge clk);
      #1;
      if (hold) ld_a = next_data;
      else      lv_a = 1'b0;
      for (int t = 0; t <= 12; t++) begin
         if (t > 0) begin
            @(posedge clk);
            #1;
         end
         a = (t / 3 > 3) ? 3 : t / 3;
         check($sformatf("%s t%0d valid", tag, t), {31'd0, bv_a}, {31'd0, (t > 0) && (t % 3 == 0)});
         if ((t > 0) && (t % 3 == 0))
            check($sformatf("%s t%0d bit", tag, t), {31'd0, bo_a}, {31'd0, data[t/3-1]});
         check($sformatf("%s t%0d last", tag, t), {31'd0, bl_a}, {31'd0, t == 12});
         check($sformatf("%s t%0d addr", tag, t), {30'd0, a1_a, a0_a}, a);
         check($sformatf("%s t%0d busy", tag, t), {31'd0, busy_a}, {31'd0, t < 12});
         check($sformatf("%s t%0d ready", tag, t), {31'd0, rdy_a}, {31'd0, t == 12});
         check($sformatf("%s t%0d in", tag, t), {28'd0, i3_a, i2_a, i1_a, i0_a}, {28'd0, data});
      end
`ifdef MUX_SELFCHECK_EN
      check({tag, " no mismatch"}, {31'd0, mm_a}, 32'd0);
`endif
   endtask

   // Watchdog: the directed sequence is short, so any overrun is a hang
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Reset for two cycles, then idle with no load
      repeat (2) @(posedge clk);
      #1;
      check_reset_a("reset");
      reset = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk);
         #1;
         check($sformatf("idle t%0d valid", t), {31'd0, bv_a}, 32'd0);
         check($sformatf("idle t%0d ready", t), {31'd0, rdy_a}, 32'd1);
         check($sformatf("idle t%0d busy", t), {31'd0, busy_a}, 32'd0);
         check($sformatf("idle t%0d addr", t), {30'd0, a1_a, a0_a}, 32'd0);
      end

      // Single word 0001
      word_a("w0001", 4'b0001, 1'b0, 4'b0000);

      // 1110 then 0101 held on load_valid, accepted straight after bit_last
      word_a("w1110", 4'b1110, 1'b1, 4'b0101);
      word_a("w0101", 4'b0101, 1'b0, 4'b0000);

      // 1011 with reset landing on edge k+5
      @(negedge clk);
      lv_a = 1'b1;
      ld_a = 4'b1011;
      @(posedge clk);
      #1;
      lv_a = 1'b0;
      for (int t = 1; t <= 4; t++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst_mid t%0d valid", t), {31'd0, bv_a}, {31'd0, t == 3});
         if (t == 3) check("rst_mid bit0", {31'd0, bo_a}, 32'd1);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_reset_a("rst_mid after");
      reset = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst_mid quiet t%0d valid", t), {31'd0, bv_a}, 32'd0);
         check($sformatf("rst_mid quiet t%0d busy", t), {31'd0, busy_a}, 32'd0);
      end

      // SETTLE_CYCLES=1: 1000 gives 0,0,0,1 every second edge
      @(negedge clk);
      lv_b = 1'b1;
      ld_b = 4'b1000;
      @(posedge clk);
      #1;
      lv_b = 1'b0;
      check("s1 t0 busy", {31'd0, busy_b}, 32'd1);
      for (int t = 1; t <= 8; t++) begin
         @(posedge clk);
         #1;
         check($sformatf("s1 t%0d valid", t), {31'd0, bv_b}, {31'd0, t % 2 == 0});
         if (t % 2 == 0)
            check($sformatf("s1 t%0d bit", t), {31'd0, bo_b}, {31'd0, t == 8});
         check($sformatf("s1 t%0d last", t), {31'd0, bl_b}, {31'd0, t == 8});
         check($sformatf("s1 t%0d addr", t), {30'd0, a1_b, a0_b}, (t / 2 > 3) ? 3 : t / 2);
      end
      check("s1 end ready", {31'd0, rdy_b}, 32'd1);

`ifdef MUX_SELFCHECK_EN
      // Mux output stuck low: 0010 mismatches at the second sample and stays sticky
      force_a = 1'b1;
      @(negedge clk);
      lv_a = 1'b1;
      ld_a = 4'b0010;
      @(posedge clk);
      #1;
      lv_a = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         @(posedge clk);
         #1;
         check($sformatf("selfchk t%0d mismatch", t), {31'd0, mm_a}, {31'd0, t >= 6});
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("selfchk cleared", {31'd0, mm_a}, 32'd0);
      reset = 1'b0;
      force_a = 1'b0;
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
